ctrl_serial_capture: RTL and testbench
======================================

CTRL_SERIAL_CAPTURE -- requirements
Module: ctrl_serial_capture

Interface
REQ-001 Parameter CLK_DIV, default 100: PCLK cycles per half shift-clock period; legal range >= 1.
REQ-002 Parameter POLL_PERIOD, default 1666667: PCLK cycles between poll starts; SHALL be >= 2*CLK_DIV*(NUM_BITS+1)+2.
REQ-003 Parameter NUM_BITS, default 8: serial bits captured per frame; legal range 2..16.
REQ-004 PCLK  in  1  sole clock, rising edge.
REQ-005 PRESERN  in  1  reset, synchronous, active-low.
REQ-006 enable  in  1  permits new frame starts.
REQ-007 data  in  1  serial controller line; low means button pressed.
REQ-008 ack  in  1  consumer has taken buttonData.
REQ-009 poll  out  1  latch pulse to controller.
REQ-010 sample  out  1  shift clock to controller.
REQ-011 buttonData  out  NUM_BITS  last completed word; 1 means pressed.
REQ-012 ready  out  1  buttonData holds an unacknowledged word.
REQ-013 overrun  out  1  sticky: an unacknowledged word was overwritten.

Function
REQ-014 Frame counter SHALL count 0..POLL_PERIOD-1 and wrap while enable=1; it SHALL hold at 0 while enable=0.
REQ-015 Frame tick = counter at POLL_PERIOD-1 with enable=1; a tick SHALL start a frame only in IDLE, otherwise it is ignored.
REQ-016 FSM states: IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE; all outputs registered.
REQ-017 IDLE: poll=0, sample=0; a frame tick moves to LATCH.
REQ-018 LATCH: poll=1 for exactly 2*CLK_DIV cycles, then SHIFT_LO with bit index 0.
REQ-019 SHIFT_LO: sample=0 for CLK_DIV cycles; on the last cycle it captures ~data into shift bit [index].
REQ-020 After a capture, if index=NUM_BITS-1 go to DONE; otherwise go to SHIFT_HI and increment index.
REQ-021 SHIFT_HI: sample=1 for CLK_DIV cycles, then SHIFT_LO; exactly NUM_BITS-1 sample pulses occur per frame.
REQ-022 First captured bit SHALL land in buttonData[0], the last in buttonData[NUM_BITS-1].
REQ-023 DONE (one cycle): load buttonData from shift register, set ready=1, then return to IDLE.
REQ-024 Latency from poll rising to ready rising SHALL be 2*CLK_DIV + (2*NUM_BITS-1)*CLK_DIV + 1 cycles.
REQ-025 ack with ready=1 SHALL clear ready next cycle; ack with ready=0 has no effect.
REQ-026 DONE with ready=1 and no ack in the same cycle SHALL set overrun=1; buttonData is still overwritten.
REQ-027 DONE and ack in the same cycle: ready stays 1 with the new word and overrun is not set.
REQ-028 overrun SHALL clear on an accepted ack unless a REQ-026 event occurs in the same cycle; that event takes priority.
REQ-029 enable deasserted mid-frame SHALL NOT abort the frame; the frame completes normally.
REQ-030 buttonData SHALL change only in DONE or on reset.

Reset
REQ-031 With PRESERN=0 at a rising PCLK edge: state=IDLE, counter=0, index=0, shift register=0, buttonData=0, poll=0, sample=0, ready=0, overrun=0.
REQ-032 Reset mid-frame SHALL abort the frame immediately; no partial word is published.
REQ-033 After reset release, the first frame SHALL start POLL_PERIOD cycles after enable is high.

Verification (CLK_DIV=2, POLL_PERIOD=64, NUM_BITS=8)
REQ-034 Data model returns pattern 0xA5 (active-low on the line, LSB first) -> poll high 4 cycles, 7 sample pulses each 2 cycles high; ready rises 35 cycles after poll rises; buttonData=0xA5.
REQ-035 ack pulse one cycle after ready rises -> ready=0 next cycle; overrun stays 0.
REQ-036 No ack across two frames -> second DONE sets overrun=1 and buttonData shows the second word; next ack clears both ready and overrun.
REQ-037 ack held high on the DONE cycle of frame 2 -> ready remains 1, overrun=0, buttonData shows the frame-2 word.
REQ-038 enable dropped during SHIFT_HI -> frame completes with ready=1; no further poll while enable=0; poll resumes 64 cycles after enable returns high.
REQ-039 PRESERN pulsed low during SHIFT_LO of bit 3 -> all outputs 0 on the next cycle; no ready until a full new frame completes.

Source files
------------

// File: rtl/ctrl_serial_capture.sv
// Serial game-controller poller: latches the pad, clocks NUM_BITS bits out of it
// and publishes each word with a ready/ack handshake and a sticky overrun flag.
module ctrl_serial_capture #(
   parameter int CLK_DIV     = 100,
   parameter int POLL_PERIOD = 1666667,
   parameter int NUM_BITS    = 8
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   input  logic                enable,
   input  logic                data,
   input  logic                ack,
   output logic                poll,
   output logic                sample,
   output logic [NUM_BITS-1:0] buttonData,
   output logic                ready,
   output logic                overrun
);

   localparam int CNT_W = $clog2(POLL_PERIOD + 1);
   localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
   localparam int IDX_W = $clog2(NUM_BITS);

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(POLL_PERIOD - 1);
   localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SHIFT_LO,
      SHIFT_HI,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_BITS-1:0] shift_q, shift_d;
   logic [NUM_BITS-1:0] button_data_q, button_data_d;
   logic                poll_q, poll_d;
   logic                sample_q, sample_d;
   logic                ready_q, ready_d;
   logic                overrun_q, overrun_d;
   logic                frame_tick;
   logic                ack_accept;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      div_d         = div_q;
      idx_d         = idx_q;
      shift_d       = shift_q;
      button_data_d = button_data_q;
      poll_d        = poll_q;
      sample_d      = sample_q;
      ready_d       = ready_q;
      overrun_d     = overrun_q;

      frame_tick = enable && (cnt_q == CNT_LAST);
      ack_accept = ack && ready_q;

      // Frame timer parks at zero whenever polling is disabled.
      if (!enable || frame_tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            poll_d   = 1'b0;
            sample_d = 1'b0;
            if (frame_tick) begin
               state_d = LATCH;
               poll_d  = 1'b1;
               div_d   = '0;
            end
         end

         LATCH: begin
            if (div_q == LATCH_LAST) begin
               state_d = SHIFT_LO;
               poll_d  = 1'b0;
               div_d   = '0;
               idx_d   = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         SHIFT_LO: begin
            if (div_q == HALF_LAST) begin
               div_d          = '0;
               shift_d[idx_q] = ~data;
               if (idx_q == IDX_LAST) begin
                  state_d = DONE;
               end else begin
                  state_d  = SHIFT_HI;
                  sample_d = 1'b1;
                  idx_d    = idx_q + IDX_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         SHIFT_HI: begin
            if (div_q == HALF_LAST) begin
               state_d  = SHIFT_LO;
               sample_d = 1'b0;
               div_d    = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         DONE: begin
            state_d       = IDLE;
            button_data_d = shift_q;
         end

         default: begin
            state_d  = IDLE;
            poll_d   = 1'b0;
            sample_d = 1'b0;
         end
      endcase

      // A word published while the previous one is still unread wins over a plain ack.
      if (state_q == DONE) begin
         ready_d = 1'b1;
         if (ready_q && !ack) begin
            overrun_d = 1'b1;
         end else if (ack_accept) begin
            overrun_d = 1'b0;
         end
      end else if (ack_accept) begin
         ready_d   = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         div_q         <= '0;
         idx_q         <= '0;
         shift_q       <= '0;
         button_data_q <= '0;
         poll_q        <= 1'b0;
         sample_q      <= 1'b0;
         ready_q       <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         div_q         <= div_d;
         idx_q         <= idx_d;
         shift_q       <= shift_d;
         button_data_q <= button_data_d;
         poll_q        <= poll_d;
         sample_q      <= sample_d;
         ready_q       <= ready_d;
         overrun_q     <= overrun_d;
      end
   end

   assign poll       = poll_q;
   assign sample     = sample_q;
   assign buttonData = button_data_q;
   assign ready      = ready_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_ctrl_serial_capture.sv
// Bench for ctrl_serial_capture: directed frame table, hand-written corner
// sequences and a randomized run against a frame-timing reference model.
module tb_ctrl_serial_capture;

   localparam int D = 2;
   localparam int P = 64;
   localparam int N = 8;
   localparam int L = 2 * D + (2 * N - 1) * D + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       ack = 1'b0;
   logic       data;
   logic       poll;
   logic       sample;
   logic [7:0] buttonData;
   logic       ready;
   logic       overrun;

   int n_vec = 0;
   int n_err = 0;
   logic chk_on = 1'b0;

   logic [7:0] next_pat = 8'h00;
   logic [7:0] line_pat = 8'h00;
   logic [7:0] env_sr = 8'h00;
   logic       env_sample_prev = 1'b0;

   int         m_cnt = 0;
   int         m_t = 0;
   logic       m_busy = 1'b0;
   logic       m_rdy = 1'b0;
   logic       m_ovr = 1'b0;
   logic [7:0] m_bd = 8'h00;
   logic [7:0] m_pat = 8'h00;
   logic       e_poll;
   logic       e_sample;

   logic       prev_rdy = 1'b0;
   logic [7:0] prev_bd = 8'h00;

   typedef struct {
      logic [7:0] pat;
      logic       ack_on_done;
      logic       exp_rdy;
      logic       exp_ovr;
      logic [7:0] exp_bd;
      logic       ack_after;
   } vec_t;

   vec_t tbl[9];

   ctrl_serial_capture #(
      .CLK_DIV    (D),
      .POLL_PERIOD(P),
      .NUM_BITS   (N)
   ) dut (
      .PCLK      (clk),
      .PRESERN   (rst_n),
      .enable    (en),
      .data      (data),
      .ack       (ack),
      .poll      (poll),
      .sample    (sample),
      .buttonData(buttonData),
      .ready     (ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Pad model: loads its buttons while latched, shifts on each rising shift clock.
   assign data = ~env_sr[0];
   always @(posedge clk) begin
      if (poll) begin
         env_sr <= line_pat;
      end else if (sample && !env_sample_prev) begin
         env_sr <= env_sr >> 1;
      end
      env_sample_prev <= sample;
   end

   // Reference: frames are fixed-length windows of L cycles started by the poll timer.
   always @(posedge clk) begin
      logic acc;
      acc = ack && m_rdy;
      if (!rst_n) begin
         m_cnt  <= 0;
         m_t    <= 0;
         m_busy <= 1'b0;
         m_rdy  <= 1'b0;
         m_ovr  <= 1'b0;
         m_bd   <= 8'h00;
      end else begin
         m_cnt <= en ? (m_cnt + 1) % P : 0;
         if (m_busy) begin
            if (m_t == L - 1) begin
               m_busy <= 1'b0;
               m_t    <= 0;
            end else begin
               m_t <= m_t + 1;
            end
         end else if (en && m_cnt == P - 1) begin
            m_busy   <= 1'b1;
            m_t      <= 0;
            m_pat    <= next_pat;
            line_pat <= next_pat;
         end
         if (m_busy && m_t == L - 1) begin
            m_bd  <= m_pat;
            m_rdy <= 1'b1;
            if (m_rdy && !ack) m_ovr <= 1'b1;
            else if (acc) m_ovr <= 1'b0;
         end else if (acc) begin
            m_rdy <= 1'b0;
            m_ovr <= 1'b0;
         end
      end
   end

   assign e_poll   = m_busy && (m_t < 2 * D);
   assign e_sample = m_busy && (m_t >= 2 * D) && (m_t < L - 1) && ((((m_t - 2 * D) / D) % 2) == 1);

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("cyc_poll", 32'(poll), 32'(e_poll));
         check("cyc_sample", 32'(sample), 32'(e_sample));
         check("cyc_ready", 32'(ready), 32'(m_rdy));
         check("cyc_overrun", 32'(overrun), 32'(m_ovr));
         check("cyc_buttonData", 32'(buttonData), 32'(m_bd));
      end
   end

   task automatic wait_poll(input string nm);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (poll) break;
      end
      check(nm, 32'(poll), 32'(1));
   endtask

   // Entered on the negedge where poll is first seen high (frame offset 0).
   task automatic do_frame(input vec_t v);
      int   pw, sh, sp;
      logic ps;
      pw = 0; sh = 0; sp = 0; ps = 1'b0;
      for (int t = 0; t <= 37; t++) begin
         if (t > 0) @(negedge clk);
         if (t <= 34) begin
            pw += int'(poll);
            sh += int'(sample);
            if (sample && !ps) sp++;
            ps = sample;
         end
         if (t == 34) begin
            check("pre_done_ready", 32'(ready), 32'(prev_rdy));
            check("pre_done_bd", 32'(buttonData), 32'(prev_bd));
            ack = v.ack_on_done;
         end
         if (t == 35) begin
            ack = 1'b0;
            check("frame_ready", 32'(ready), 32'(v.exp_rdy));
            check("frame_overrun", 32'(overrun), 32'(v.exp_ovr));
            check("frame_bd", 32'(buttonData), 32'(v.exp_bd));
            check("poll_width", 32'(pw), 32'(4));
            check("sample_pulses", 32'(sp), 32'(7));
            check("sample_high_cycles", 32'(sh), 32'(14));
         end
         if (t == 36 && v.ack_after) ack = 1'b1;
         if (t == 37 && v.ack_after) begin
            ack = 1'b0;
            check("ack_clears_ready", 32'(ready), 32'(0));
            check("ack_clears_overrun", 32'(overrun), 32'(0));
         end
      end
      prev_rdy = v.ack_after ? 1'b0 : v.exp_rdy;
      prev_bd  = v.exp_bd;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int got;
      int cnt;

      tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
      tbl[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
      tbl[2] = '{8'h81, 1'b0, 1'b1, 1'b1, 8'h81, 1'b1};
      tbl[3] = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0};
      tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};
      tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
      tbl[6] = '{8'h6E, 1'b1, 1'b1, 1'b0, 8'h6E, 1'b1};
      tbl[7] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1};
      tbl[8] = '{8'h80, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0};

      repeat (3) @(negedge clk);
      check("rst_poll", 32'(poll), 32'(0));
      check("rst_sample", 32'(sample), 32'(0));
      check("rst_ready", 32'(ready), 32'(0));
      check("rst_overrun", 32'(overrun), 32'(0));
      check("rst_bd", 32'(buttonData), 32'(0));
      chk_on = 1'b1;

      next_pat = tbl[0].pat;
      rst_n = 1'b1;
      en = 1'b1;
      got = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (poll) begin
            got = k;
            break;
         end
      end
      check("first_poll_delay", 32'(got), 32'(64));

      for (int i = 0; i < 9; i++) begin
         next_pat = tbl[i].pat;
         if (i > 0) wait_poll("wait_poll_tbl");
         do_frame(tbl[i]);
      end

      // Enable dropped in the middle of a frame.
      next_pat = 8'h42;
      wait_poll("wait_poll_endrop");
      for (int t = 1; t <= 35; t++) begin
         @(negedge clk);
         if (t == 10) en = 1'b0;
      end
      check("endrop_ready", 32'(ready), 32'(1));
      check("endrop_bd", 32'(buttonData), 32'(8'h42));
      check("endrop_overrun", 32'(overrun), 32'(1));
      cnt = 0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         cnt += int'(poll);
      end
      check("no_poll_disabled", 32'(cnt), 32'(0));
      next_pat = 8'h99;
      en = 1'b1;
      got = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (poll) begin
            got = k;
            break;
         end
      end
      check("poll_resume_delay", 32'(got), 32'(64));

      // Reset during the low phase of bit 3.
      for (int t = 1; t <= 16; t++) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_poll", 32'(poll), 32'(0));
      check("midrst_sample", 32'(sample), 32'(0));
      check("midrst_ready", 32'(ready), 32'(0));
      check("midrst_overrun", 32'(overrun), 32'(0));
      check("midrst_bd", 32'(buttonData), 32'(0));
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 99; k++) begin
         @(negedge clk);
         if (k < 99) cnt += int'(ready);
      end
      check("midrst_no_early_ready", 32'(cnt), 32'(0));
      check("midrst_new_ready", 32'(ready), 32'(1));
      check("midrst_new_bd", 32'(buttonData), 32'(8'h99));

      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         ack      = ($urandom_range(0, 3) == 0);
         next_pat = 8'($urandom);
         if ($urandom_range(0, 149) == 0) en = ~en;
         rst_n    = ($urandom_range(0, 1499) != 0);
      end
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
